// File: rtl/conv_parallel_to_seq.sv
// Parallel-to-serial pixel converter: each accepted word of p_words pixels is
// emitted LSB-first, one pixel per transfer. Optional macro: CONV_P2S_EOL_EN.
//
// state | meaning
// EMPTY | cnt == 0, nothing buffered, a new word can be accepted
// DRAIN | cnt >= 1, pixels remain in shreg; the last one may overlap a load
module conv_parallel_to_seq #(
  parameter int C_ROW_SIZE = 8,
  parameter int p_dataBits = 8,
  parameter int p_words    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [p_words*p_dataBits-1:0] data_in,
  input  logic                          valid_in,
  input  logic                          sof_in,
  output logic                          busy_out,
  output logic [p_dataBits-1:0]         data_out,
  output logic                          valid_out,
  output logic                          sof_out,
  input  logic                          busy_in
`ifdef CONV_P2S_EOL_EN
  ,
  output logic                          eol_out
`endif
);

  localparam int CW = $clog2(p_words + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(p_words);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [p_words*p_dataBits-1:0] shreg;
  logic [CW-1:0]                 cnt;
  logic                          sof_pend;
  logic                          out_ready;
  logic                          accept;

  assign out_ready = !valid_out || !busy_in;
  assign busy_out  = (cnt > CNT_ONE) || ((cnt == CNT_ONE) && !out_ready);
  assign accept    = valid_in && !busy_out;

  // A load in the same cycle as the last pixel leaving overrides the shift.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg     <= '0;
      cnt       <= '0;
      sof_pend  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
    end else begin
      if (out_ready) begin
        if (cnt != '0) begin
          data_out  <= shreg[p_dataBits-1:0];
          valid_out <= 1'b1;
          sof_out   <= sof_pend;
          sof_pend  <= 1'b0;
          shreg     <= shreg >> p_dataBits;
          cnt       <= cnt - CNT_ONE;
        end else begin
          valid_out <= 1'b0;
          sof_out   <= 1'b0;
        end
      end
      if (accept) begin
        shreg    <= data_in;
        cnt      <= CNT_FULL;
        sof_pend <= sof_in;
      end
    end
  end

`ifdef CONV_P2S_EOL_EN
  localparam int COLW = (C_ROW_SIZE > 1) ? $clog2(C_ROW_SIZE) : 1;
  localparam logic [COLW-1:0] COL_LAST = COLW'(C_ROW_SIZE - 1);

  logic [COLW-1:0] col;
  logic [COLW-1:0] col_next;

  // Column restarts on a frame start, independent of word alignment.
  always_comb begin
    col_next = '0;
    if (!sof_pend && (col != COL_LAST)) col_next = col + COLW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col     <= '0;
      eol_out <= 1'b0;
    end else if (out_ready) begin
      if (cnt != '0) begin
        col     <= col_next;
        eol_out <= (col_next == COL_LAST);
      end else begin
        eol_out <= 1'b0;
      end
    end
  end
`endif

endmodule
